// File: rtl/ps2_kbd_event_fifo.sv
// ps2_kbd_event_fifo
//
// Turns raw PS/2 set-2 scancode bytes into single key events and queues
// them for the CPU.
//   - E0 (extended) and F0 (break) prefixes are folded into the event flags.
//   - The 8-byte Pause sequence (starting with E1) is collapsed into one
//     event {brk=0, ext=1, code=E1}.
//   - Controller response bytes (AA/FA/FE/EE/00/FF) seen in IDLE are not
//     queued. They are reported on o_ctrl_code/o_ctrl_stb instead.
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_code/i_strobe  received byte, qualified by the one-cycle strobe
//   i_err            one-cycle receiver error pulse: resyncs the decoder
//   o_valid/o_event  FIFO head {brk, ext, code[7:0]}
//   i_read           pop request
//   o_level          number of stored events (0..DEPTH)
//   o_overflow       sticky: an event was dropped because the FIFO was full
//   o_rx_err         sticky: i_err was seen
//   i_clr            clears both sticky flags; a set in the same cycle wins
//   o_ctrl_code/stb  last filtered controller byte and its one-cycle pulse
//   o_dbg_state      decoder state (0 IDLE, 1 PREFIX, 2 PAUSE)
//
// Read handshake: o_valid=1 means o_event holds the oldest entry. The entry
// is consumed on a rising edge where o_valid=1 and i_read=1. i_read is
// ignored while o_valid=0. o_event stays stable until that edge, and it keeps
// the last head value while the FIFO is empty.

module ps2_kbd_event_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_code,
    input  logic        i_strobe,
    input  logic        i_err,
    output logic        o_valid,
    output logic [9:0]  o_event,
    input  logic        i_read,
    output logic [AW:0] o_level,
    output logic        o_overflow,
    output logic        o_rx_err,
    input  logic        i_clr,
    output logic [7:0]  o_ctrl_code,
    output logic        o_ctrl_stb,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PREFIX = 2'd1,
        S_PAUSE  = 2'd2
    } state_t;

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);

    state_t      state, state_n;
    logic        ext_q, ext_n;
    logic        brk_q, brk_n;
    logic [2:0]  skip_q, skip_n;
    logic        push;
    logic [9:0]  push_data;
    logic        ctrl_hit;

    logic [9:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [AW:0] count, count_n;
    logic [9:0]  head_q, head_n;
    logic        full, pop, push_ok, ovf_set;
    logic        overflow_q, rx_err_q;
    logic [7:0]  ctrl_code_q;
    logic        ctrl_stb_q;

    // ---------------- decoder: state register ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= S_IDLE;
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            skip_q <= 3'd0;
        end else begin
            state  <= state_n;
            ext_q  <= ext_n;
            brk_q  <= brk_n;
            skip_q <= skip_n;
        end
    end

    // ---------------- decoder: next state / emit ----------------
    always_comb begin
        state_n   = state;
        ext_n     = ext_q;
        brk_n     = brk_q;
        skip_n    = skip_q;
        push      = 1'b0;
        push_data = 10'd0;
        ctrl_hit  = 1'b0;
        if (i_err) begin
            // Resync: a byte strobed together with the error is discarded.
            state_n = S_IDLE;
            ext_n   = 1'b0;
            brk_n   = 1'b0;
            skip_n  = 3'd0;
        end else if (i_strobe) begin
            case (state)
                S_IDLE: begin
                    if (i_code == 8'hE0) begin
                        ext_n   = 1'b1;
                        state_n = S_PREFIX;
                    end else if (i_code == 8'hF0) begin
                        brk_n   = 1'b1;
                        state_n = S_PREFIX;
                    end else if (i_code == 8'hE1) begin
                        skip_n  = 3'd7;
                        state_n = S_PAUSE;
                    end else if (i_code inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) begin
                        ctrl_hit = 1'b1;
                    end else begin
                        push      = 1'b1;
                        push_data = {2'b00, i_code};
                    end
                end
                S_PREFIX: begin
                    // Controller bytes are ordinary key codes after a prefix.
                    if (i_code == 8'hE0) begin
                        ext_n = 1'b1;
                    end else if (i_code == 8'hF0) begin
                        brk_n = 1'b1;
                    end else begin
                        push      = 1'b1;
                        push_data = {brk_q, ext_q, i_code};
                        ext_n     = 1'b0;
                        brk_n     = 1'b0;
                        state_n   = S_IDLE;
                    end
                end
                S_PAUSE: begin
                    skip_n = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        push      = 1'b1;
                        push_data = {2'b01, 8'hE1};
                        state_n   = S_IDLE;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // ---------------- FIFO control ----------------
    always_comb begin
        full    = (count == FULL_LVL);
        pop     = i_read && (count != '0);
        // When full, a same-cycle pop frees the slot the push needs.
        push_ok = push && (!full || pop);
        ovf_set = push && full && !pop;
        rd_nxt  = rd_ptr + AW'(1);

        count_n = count;
        case ({push_ok, pop})
            2'b10:   count_n = count + ONE_LVL;
            2'b01:   count_n = count - ONE_LVL;
            default: count_n = count;
        endcase

        // The head is registered so it can hold its last value when empty.
        head_n = head_q;
        if (pop) begin
            if (count == ONE_LVL) begin
                if (push_ok) head_n = push_data;
            end else begin
                head_n = mem[rd_nxt];
            end
        end else if (count == '0 && push_ok) begin
            head_n = push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            head_q      <= 10'd0;
            overflow_q  <= 1'b0;
            rx_err_q    <= 1'b0;
            ctrl_code_q <= 8'd0;
            ctrl_stb_q  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_nxt;
            count       <= count_n;
            head_q      <= head_n;
            overflow_q  <= (overflow_q & ~i_clr) | ovf_set;
            rx_err_q    <= (rx_err_q & ~i_clr) | i_err;
            if (ctrl_hit) ctrl_code_q <= i_code;
            ctrl_stb_q  <= ctrl_hit;
        end
    end

    assign o_valid     = (count != '0);
    assign o_event     = head_q;
    assign o_level     = count;
    assign o_overflow  = overflow_q;
    assign o_rx_err    = rx_err_q;
    assign o_ctrl_code = ctrl_code_q;
    assign o_ctrl_stb  = ctrl_stb_q;
    assign o_dbg_state = state;

endmodule

// File: tb/tb_ps2_kbd_event_fifo.sv
module tb_ps2_kbd_event_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic        clk;
    logic        rst_n;
    logic [7:0]  code;
    logic        strobe;
    logic        err;
    logic        valid;
    logic [9:0]  event_w;
    logic        read;
    logic [AW:0] level;
    logic        overflow;
    logic        rx_err;
    logic        clr;
    logic [7:0]  ctrl_code;
    logic        ctrl_stb;
    logic [1:0]  dbg_state;

    ps2_kbd_event_fifo #(.DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_code      (code),
        .i_strobe    (strobe),
        .i_err       (err),
        .o_valid     (valid),
        .o_event     (event_w),
        .i_read      (read),
        .o_level     (level),
        .o_overflow  (overflow),
        .o_rx_err    (rx_err),
        .i_clr       (clr),
        .o_ctrl_code (ctrl_code),
        .o_ctrl_stb  (ctrl_stb),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [9:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change on the falling edge; outputs are sampled on the next
    // falling edge, after the rising edge that consumed the inputs.
    task automatic drive(input logic [7:0] c, input logic s, input logic r,
                         input logic e, input logic k);
        @(negedge clk);
        code = c; strobe = s; read = r; err = e; clr = k;
        @(negedge clk);
        strobe = 1'b0; read = 1'b0; err = 1'b0; clr = 1'b0;
    endtask

    task automatic send(input logic [7:0] c);
        drive(c, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_one();
        drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // Checks the level, then pops and compares every queued expectation.
    task automatic drain(input string name);
        logic [9:0] e;
        check({name, "_level"}, 32'(level), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({name, "_valid"}, 32'(valid), 32'd1);
            check({name, "_event"}, 32'(event_w), 32'(e));
            pop_one();
        end
        check({name, "_empty"}, 32'(valid), 32'd0);
    endtask

    // ---------------- vector table ----------------
    // bytes: first byte in the top 8 bits; ev: first event in the top 10 bits.
    typedef struct packed {
        logic [3:0]  n_bytes;
        logic [63:0] bytes;
        logic [1:0]  n_ev;
        logic [19:0] ev;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    function automatic vec_t mk(input int nb, input logic [63:0] b, input int ne,
                                input logic [9:0] e0, input logic [9:0] e1);
        vec_t v;
        v.n_bytes = 4'(nb);
        v.bytes   = b;
        v.n_ev    = 2'(ne);
        v.ev      = {e0, e1};
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(1, 64'h1C00_0000_0000_0000, 1, 10'h01C, 10'h000);
        vecs[1]  = mk(3, 64'hE0F0_7400_0000_0000, 1, 10'h374, 10'h000);
        vecs[2]  = mk(2, 64'hF01C_0000_0000_0000, 1, 10'h21C, 10'h000);
        vecs[3]  = mk(8, 64'hE114_77E1_F014_F077, 1, 10'h1E1, 10'h000);
        vecs[4]  = mk(1, 64'h1C00_0000_0000_0000, 1, 10'h01C, 10'h000);
        vecs[5]  = mk(2, 64'hE0FA_0000_0000_0000, 1, 10'h1FA, 10'h000);
        vecs[6]  = mk(2, 64'hE075_0000_0000_0000, 1, 10'h175, 10'h000);
        vecs[7]  = mk(3, 64'hF0E0_6B00_0000_0000, 1, 10'h36B, 10'h000);
        vecs[8]  = mk(2, 64'hF0AA_0000_0000_0000, 1, 10'h2AA, 10'h000);
        vecs[9]  = mk(2, 64'h0015_0000_0000_0000, 1, 10'h015, 10'h000);
        vecs[10] = mk(1, 64'hAA00_0000_0000_0000, 0, 10'h000, 10'h000);
        vecs[11] = mk(3, 64'hE0E0_1200_0000_0000, 1, 10'h112, 10'h000);
        vecs[12] = mk(3, 64'hF012_5900_0000_0000, 2, 10'h212, 10'h059);
    end

    // ---------------- test sequence ----------------
    initial begin
        rst_n = 1'b0; code = 8'h00; strobe = 1'b0; read = 1'b0; err = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_event", 32'(event_w), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_rxerr", 32'(rx_err), 32'd0);
        check("rst_ctrl", 32'(ctrl_code), 32'd0);
        check("rst_ctrl_stb", 32'(ctrl_stb), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // first event latency: visible one cycle after the strobe
        send(8'h1C);
        check("lat_valid", 32'(valid), 32'd1);
        check("lat_event", 32'(event_w), 32'h01C);
        check("lat_level", 32'(level), 32'd1);
        pop_one();
        check("lat_pop_valid", 32'(valid), 32'd0);
        check("lat_pop_level", 32'(level), 32'd0);
        check("lat_hold_event", 32'(event_w), 32'h01C);

        // table-driven decoder vectors
        for (int i = 0; i < NV; i++) begin
            for (int b = 0; b < int'(vecs[i].n_bytes); b++) begin
                send(vecs[i].bytes[63-8*b -: 8]);
                @(negedge clk);
            end
            for (int j = 0; j < int'(vecs[i].n_ev); j++)
                exp_q.push_back(vecs[i].ev[19-10*j -: 10]);
            drain($sformatf("vec%0d", i));
        end

        // controller byte filter and one-cycle strobe
        send(8'hFE);
        check("ctrl_stb_hi", 32'(ctrl_stb), 32'd1);
        check("ctrl_code", 32'(ctrl_code), 32'hFE);
        check("ctrl_no_push", 32'(level), 32'd0);
        @(negedge clk);
        check("ctrl_stb_lo", 32'(ctrl_stb), 32'd0);
        check("ctrl_code_hold", 32'(ctrl_code), 32'hFE);

        // overflow: 17 pushes into 16 entries
        for (int i = 1; i <= 17; i++) begin
            send(8'(i));
            if (i <= DEPTH) exp_q.push_back(10'(i));
        end
        check("ovf_level", 32'(level), 32'(DEPTH));
        check("ovf_flag", 32'(overflow), 32'd1);
        drain("ovf_drain");
        check("ovf_sticky", 32'(overflow), 32'd1);
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovf_clr", 32'(overflow), 32'd0);

        // full + push + pop in the same cycle
        for (int i = 0; i < DEPTH; i++) begin
            send(8'(8'h20 + i));
            exp_q.push_back(10'(8'h20 + i));
        end
        drive(8'h30, 1'b1, 1'b1, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        exp_q.push_back(10'h030);
        check("fullrw_level", 32'(level), 32'(DEPTH));
        check("fullrw_ovf", 32'(overflow), 32'd0);
        check("fullrw_head", 32'(event_w), 32'h021);
        // clear and new overflow together: set wins, contents unchanged
        drive(8'h31, 1'b1, 1'b0, 1'b0, 1'b1);
        check("clrset_ovf", 32'(overflow), 32'd1);
        check("clrset_level", 32'(level), 32'(DEPTH));
        drain("full_drain");
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // pointer wrap: 40 push/pop pairs, read on empty is ignored
        for (int k = 0; k < 40; k++) begin
            if (k > 0) check("wrap_head", 32'(event_w), 32'(exp_q[0]));
            drive(8'(8'h40 + k), 1'b1, 1'b1, 1'b0, 1'b0);
            if (k > 0) void'(exp_q.pop_front());
            exp_q.push_back(10'(8'h40 + k));
            check("wrap_level", 32'(level), 32'd1);
        end
        drain("wrap_drain");

        // receiver error resyncs the decoder
        send(8'hE0);
        check("err_prefix_state", 32'(dbg_state), 32'd1);
        drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("err_flag", 32'(rx_err), 32'd1);
        check("err_idle_state", 32'(dbg_state), 32'd0);
        send(8'h1C);
        exp_q.push_back(10'h01C);
        drive(8'h22, 1'b1, 1'b0, 1'b1, 1'b0);
        drain("err_drain");
        drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        check("err_clrset", 32'(rx_err), 32'd1);
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("err_clr", 32'(rx_err), 32'd0);

        // asynchronous reset mid-stream
        send(8'h50);
        send(8'h51);
        send(8'h52);
        drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        send(8'hAA);
        check("mid_level", 32'(level), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_event", 32'(event_w), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_rxerr", 32'(rx_err), 32'd0);
        check("mid_rst_ctrl", 32'(ctrl_code), 32'd0);
        check("mid_rst_stb", 32'(ctrl_stb), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h1C);
        exp_q.push_back(10'h01C);
        drain("post_rst");

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
